// File: rtl/fnd_display_scheduler_if.sv
// Bundle between the FND display scheduler and the logic around it.
// The master drives the value sources and requests; the slave (the scheduler)
// returns the scan tick, the display value and the acknowledges.
interface fnd_display_scheduler_if;
    logic [13:0] main_data;
    logic        ev1_req;
    logic [13:0] ev1_data;
    logic        ev2_req;
    logic [13:0] ev2_data;
    logic        tick;
    logic [13:0] out_data;
    logic        ovf;
    logic [1:0]  active_src;
    logic        ev1_ack;
    logic        ev2_ack;

    modport master (
        output main_data, ev1_req, ev1_data, ev2_req, ev2_data,
        input  tick, out_data, ovf, active_src, ev1_ack, ev2_ack
    );

    modport slave (
        input  main_data, ev1_req, ev1_data, ev2_req, ev2_data,
        output tick, out_data, ovf, active_src, ev1_ack, ev2_ack
    );
endinterface

// File: rtl/fnd_display_scheduler.sv
// FND display scheduler: free-running digit-scan tick divider plus a small
// arbiter that lets two event sources take over the display for HOLD_TICKS
// scan ticks. ev2 outranks ev1; the displayed value is registered and
// saturated to MAX_VAL.
module fnd_display_scheduler #(
    parameter int TICK_DIV   = 100_000,
    parameter int HOLD_TICKS = 2000,
    parameter int MAX_VAL    = 9999
) (
    input  logic                          clk,
    input  logic                          reset,
    fnd_display_scheduler_if.slave        bus
);

    localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(HOLD_TICKS + 1);

    localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_TICKS);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [13:0]   MAX14     = 14'(MAX_VAL);

    typedef enum logic [1:0] {
        SHOW_MAIN = 2'd0,
        SHOW_EV1  = 2'd1,
        SHOW_EV2  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [DW-1:0] r_div;
    logic [HW-1:0] r_hold;
    logic [13:0]   r_ev_data;
    logic [13:0]   r_out;
    logic          r_ovf;
    logic [1:0]    r_src;
    logic          r_ack1;
    logic          r_ack2;
    logic          w_tick;
    logic          w_acc1;
    logic          w_acc2;
    logic [13:0]   w_sel;

    // Tick is a pure decode of the divider, so it is high for exactly one
    // cycle per period and drops to 0 the instant reset asserts.
    assign w_tick = (r_div == DIV_LAST);

    // Free-running scan divider, independent of the arbiter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_div <= '0;
        else if (w_tick) r_div <= '0;
        else             r_div <= r_div + 1'b1;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= SHOW_MAIN;
        else       r_state <= w_next;
    end

    // Arbitration and next state: ev2 is accepted in every state, ev1 only
    // when ev2 is not requesting and ev2 does not own the display. Acceptance
    // beats hold expiry on the same edge.
    always_comb begin
        w_acc1 = 1'b0;
        w_acc2 = 1'b0;
        w_next = r_state;
        if (bus.ev2_req)
            w_acc2 = 1'b1;
        else if (bus.ev1_req && (r_state != SHOW_EV2))
            w_acc1 = 1'b1;

        if (w_acc2)
            w_next = SHOW_EV2;
        else if (w_acc1)
            w_next = SHOW_EV1;
        else if ((r_state != SHOW_MAIN) && w_tick && (r_hold == HOLD_ONE))
            w_next = SHOW_MAIN;
    end

    // Hold counter: reload on acceptance (no decrement that edge), else count
    // scan ticks down while an event owns the display.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_hold <= '0;
        else if (w_acc1 || w_acc2)
            r_hold <= HOLD_INIT;
        else if ((r_state != SHOW_MAIN) && w_tick && (r_hold != '0))
            r_hold <= r_hold - 1'b1;
    end

    // Latch the accepted event value and pulse the matching acknowledge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ev_data <= '0;
            r_ack1    <= 1'b0;
            r_ack2    <= 1'b0;
        end else begin
            r_ack1 <= w_acc1;
            r_ack2 <= w_acc2;
            if (w_acc2)
                r_ev_data <= bus.ev2_data;
            else if (w_acc1)
                r_ev_data <= bus.ev1_data;
        end
    end

    assign w_sel = (r_state == SHOW_MAIN) ? bus.main_data : r_ev_data;

    // Registered, saturated output stage; active_src is registered with it so
    // source and value always describe the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out <= '0;
            r_ovf <= 1'b0;
            r_src <= 2'd0;
        end else begin
            r_out <= (w_sel > MAX14) ? MAX14 : w_sel;
            r_ovf <= (w_sel > MAX14);
            r_src <= r_state;
        end
    end

    assign bus.tick       = w_tick;
    assign bus.out_data   = r_out;
    assign bus.ovf        = r_ovf;
    assign bus.active_src = r_src;
    assign bus.ev1_ack    = r_ack1;
    assign bus.ev2_ack    = r_ack2;

endmodule
